// File: rtl/sdram_arb_pkg.sv
// Shared types and the round-robin search for the SDRAM port arbiter.
// Build option SDRAM_ARB_FIXED_PRIO_EN (see sdram_rr_picker) selects fixed priority instead.
package sdram_arb_pkg;

  localparam int MAX_NPORTS = 4;
  localparam int PIDX_W     = 2;

  typedef logic [PIDX_W-1:0] port_idx_t;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ACCEPT, S_RUN, S_GAP} state_e;

  // First set bit after 'last', wrapping modulo nports. The loop runs downward
  // so that the nearest candidate is the last assignment and wins.
  function automatic port_idx_t rr_pick(input logic [MAX_NPORTS-1:0] req,
                                        input port_idx_t             last,
                                        input int                    nports);
    int idx;
    rr_pick = last;
    for (int i = MAX_NPORTS; i >= 1; i--) begin
      if (i <= nports) begin
        idx = int'(last) + i;
        if (idx >= nports) idx = idx - nports;
        if (req[idx[PIDX_W-1:0]]) rr_pick = port_idx_t'(idx);
      end
    end
  endfunction

endpackage

// File: rtl/sdram_rr_picker.sv
// Combinational grant selector: round-robin after last_i, or lowest index
// first when SDRAM_ARB_FIXED_PRIO_EN is defined.
module sdram_rr_picker
  import sdram_arb_pkg::*;
#(
  parameter int NPORTS = 2
) (
  input  logic [NPORTS-1:0] req_i,
  input  port_idx_t         last_i,
  output port_idx_t         grant_o,
  output logic              valid_o
);

  assign valid_o = |req_i;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_o = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (req_i[i]) grant_o = port_idx_t'(i);
    end
  end
`else
  logic [MAX_NPORTS-1:0] req_ext;

  always_comb begin
    req_ext             = '0;
    req_ext[NPORTS-1:0] = req_i;
  end

  assign grant_o = rr_pick(req_ext, last_i, NPORTS);
`endif

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one single-beat SDRAM controller among NPORTS requesters, one transaction
// in flight, with acceptance check and refresh-drop retry. Option: SDRAM_ARB_FIXED_PRIO_EN.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NPORTS      = 2,
  parameter int HADDR_WIDTH = 24,
  parameter int DATA_WIDTH  = 16,
  parameter int ACCEPT_WAIT = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NPORTS-1:0]                   req_valid,
  input  logic [NPORTS-1:0]                   req_we,
  input  logic [NPORTS-1:0][HADDR_WIDTH-1:0]  req_addr,
  input  logic [NPORTS-1:0][DATA_WIDTH-1:0]   req_wdata,
  output logic [NPORTS-1:0]                   req_ready,
  output logic [NPORTS-1:0]                   rsp_valid,
  output logic [NPORTS-1:0]                   wr_done,
  output logic [DATA_WIDTH-1:0]               rsp_rdata,
  output logic [HADDR_WIDTH-1:0]              ctl_wr_addr,
  output logic [DATA_WIDTH-1:0]               ctl_wr_data,
  output logic                                ctl_wr_enable,
  output logic [HADDR_WIDTH-1:0]              ctl_rd_addr,
  output logic                                ctl_rd_enable,
  input  logic [DATA_WIDTH-1:0]               ctl_rd_data,
  input  logic                                ctl_rd_ready,
  input  logic                                ctl_busy
);

  state_e                  state_q, state_d;
  port_idx_t               g_q, g_d, last_q, last_d, pick;
  logic                    we_q, we_d, pick_vld;
  logic [HADDR_WIDTH-1:0]  addr_q, addr_d, sel_addr;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, sel_wdata, rdata_q, rdata_d;
  logic [2:0]              wcnt_q, wcnt_d;
  logic [NPORTS-1:0]       rsp_vld_q, rsp_vld_d, pick_oh, g_oh;
  logic                    sel_we, rdy_c, wren_c, rden_c;
  logic [NPORTS-1:0]       rdy_oh_c, wdone_c;

  sdram_rr_picker #(.NPORTS(NPORTS)) u_pick (
    .req_i   (req_valid),
    .last_i  (last_q),
    .grant_o (pick),
    .valid_o (pick_vld)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    pick_oh   = '0;
    g_oh      = '0;
    for (int p = 0; p < NPORTS; p++) begin
      pick_oh[p] = (pick == port_idx_t'(p));
      g_oh[p]    = (g_q == port_idx_t'(p));
      if (pick == port_idx_t'(p)) begin
        sel_we    = req_we[p];
        sel_addr  = req_addr[p];
        sel_wdata = req_wdata[p];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    last_d    = last_q;
    wcnt_d    = wcnt_q;
    rdata_d   = rdata_q;
    rsp_vld_d = '0;
    rdy_c     = 1'b0;
    wren_c    = 1'b0;
    rden_c    = 1'b0;
    wdone_c   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (!ctl_busy && pick_vld) begin
          rdy_c   = 1'b1;
          g_d     = pick;
          last_d  = pick;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wren_c  = we_q;
        rden_c  = ~we_q;
        wcnt_d  = '0;
        state_d = S_ACCEPT;
      end
      S_ACCEPT: begin
        if (ctl_busy)                             state_d = S_RUN;
        else if (wcnt_q == 3'(ACCEPT_WAIT - 1))   state_d = S_ISSUE;
        else                                      wcnt_d  = wcnt_q + 3'd1;
      end
      S_RUN: begin
        if (!we_q) begin
          if (ctl_rd_ready) begin
            rdata_d   = ctl_rd_data;
            rsp_vld_d = g_oh;
            state_d   = S_GAP;
          end else if (!ctl_busy) begin
            // busy fell without data: the read was lost to a refresh
            state_d = S_ISSUE;
          end
        end else if (!ctl_busy) begin
          wdone_c = g_oh;
          state_d = S_GAP;
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rdy_oh_c = rdy_c ? pick_oh : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      g_q       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      last_q    <= port_idx_t'(NPORTS - 1);
      wcnt_q    <= '0;
      rdata_q   <= '0;
      rsp_vld_q <= '0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      last_q    <= last_d;
      wcnt_q    <= wcnt_d;
      rdata_q   <= rdata_d;
      rsp_vld_q <= rsp_vld_d;
    end
  end

  // Mealy outputs are held low while reset is asserted
  assign req_ready     = rst_n ? rdy_oh_c : '0;
  assign wr_done       = rst_n ? wdone_c  : '0;
  assign ctl_wr_enable = rst_n & wren_c;
  assign ctl_rd_enable = rst_n & rden_c;
  assign rsp_valid     = rsp_vld_q;
  assign rsp_rdata     = rdata_q;
  assign ctl_wr_addr   = addr_q;
  assign ctl_rd_addr   = addr_q;
  assign ctl_wr_data   = wdata_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: SDRAM controller model, per-port request queues,
// table-driven single transactions plus multi-cycle corner sequences, completion scoreboard.
module tb_sdram_port_arbiter;

  localparam int NPORTS = 2;
  localparam int HW     = 24;
  localparam int DW     = 16;
  localparam int AWAIT  = 3;
  localparam int LAT    = 3;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NPORTS-1:0]      req_valid = '0, req_we = '0;
  logic [NPORTS*HW-1:0]   req_addr = '0;
  logic [NPORTS*DW-1:0]   req_wdata = '0;
  logic [NPORTS-1:0]      req_ready, rsp_valid, wr_done;
  logic [DW-1:0]          rsp_rdata, ctl_wr_data;
  logic [HW-1:0]          ctl_wr_addr, ctl_rd_addr;
  logic                   ctl_wr_enable, ctl_rd_enable;
  logic [DW-1:0]          ctl_rd_data = '0;
  logic                   ctl_rd_ready = 1'b0, ctl_busy = 1'b0;

  sdram_port_arbiter #(.NPORTS(NPORTS), .HADDR_WIDTH(HW), .DATA_WIDTH(DW), .ACCEPT_WAIT(AWAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .wr_done(wr_done), .rsp_rdata(rsp_rdata),
    .ctl_wr_addr(ctl_wr_addr), .ctl_wr_data(ctl_wr_data), .ctl_wr_enable(ctl_wr_enable),
    .ctl_rd_addr(ctl_rd_addr), .ctl_rd_enable(ctl_rd_enable),
    .ctl_rd_data(ctl_rd_data), .ctl_rd_ready(ctl_rd_ready), .ctl_busy(ctl_busy)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // ---------------- controller model ----------------
  int          drop_arm = 0, ign_arm = 0, drop_used = 0, ign_used = 0;
  logic        busy_int = 1'b0, cur_we = 1'b0, cur_drop = 1'b0;
  int          cnt = 0;
  logic [HW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_data = '0;
  bit   [DW-1:0] mem [bit [HW-1:0]];

  always @(posedge clk) begin
    ctl_rd_ready <= 1'b0;
    ctl_busy     <= busy_int;
    if (!busy_int) begin
      if (ctl_wr_enable || ctl_rd_enable) begin
        if (ign_used < ign_arm) ign_used <= ign_used + 1;
        else begin
          busy_int <= 1'b1;
          cur_we   <= ctl_wr_enable;
          cur_addr <= ctl_wr_enable ? ctl_wr_addr : ctl_rd_addr;
          cur_data <= ctl_wr_data;
          if (ctl_rd_enable && drop_used < drop_arm) begin
            cur_drop <= 1'b1; drop_used <= drop_used + 1; cnt <= 6;
          end else begin
            cur_drop <= 1'b0; cnt <= LAT;
          end
        end
      end
    end else if (cnt > 1) cnt <= cnt - 1;
    else begin
      busy_int <= 1'b0;
      if (!cur_drop) begin
        if (cur_we) mem[cur_addr] = cur_data;
        else begin
          ctl_rd_ready <= 1'b1;
          ctl_rd_data  <= mem[cur_addr];
        end
      end
    end
  end

  // ---------------- request drivers ----------------
  typedef struct { bit we; logic [HW-1:0] addr; logic [DW-1:0] wd; } req_t;
  req_t q0[$], q1[$];
  bit [NPORTS-1:0] taken = '0;

  initial begin
    req_t r;
    bit   have;
    forever begin
      @(posedge clk); #1;
      for (int p = 0; p < NPORTS; p++) begin
        if (taken[p]) begin req_valid[p] = 1'b0; taken[p] = 1'b0; end
        have = 0;
        if (!req_valid[p]) begin
          if (p == 0 && q0.size() > 0) begin r = q0.pop_front(); have = 1; end
          if (p == 1 && q1.size() > 0) begin r = q1.pop_front(); have = 1; end
        end
        if (have) begin
          req_valid[p]            = 1'b1;
          req_we[p]               = r.we;
          req_addr[p*HW +: HW]    = r.addr;
          req_wdata[p*DW +: DW]   = r.wd;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  typedef struct { int port; bit we; logic [DW-1:0] rdata; } exp_t;
  exp_t          sbq[$];
  int            gq[$];
  int            wr_cyc[$];
  logic [HW-1:0] rd_addrs[$];
  bit [DW-1:0]   ref_mem [bit [HW-1:0]];
  int            n_wr = 0, n_rd = 0, done_cnt = 0;

  function automatic int idx_of(input logic [NPORTS-1:0] v);
    for (int i = 0; i < NPORTS; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    int   p;
    logic [HW-1:0] a;
    if (!rst_n) sbq.delete();
    else begin
      if (ctl_wr_enable && ctl_rd_enable) chk("both_enables", 1, 0);
      if (ctl_wr_enable) begin n_wr++; wr_cyc.push_back(cyc); end
      if (ctl_rd_enable) begin n_rd++; rd_addrs.push_back(ctl_rd_addr); end
      if (req_ready != '0) begin
        chk("ready_onehot", $countones(req_ready), 1);
        p = idx_of(req_ready);
        if (gq.size() > 0) chk("grant_order", p, gq.pop_front());
        taken[p] = 1'b1;
        a = req_addr[p*HW +: HW];
        e.port = p; e.we = req_we[p]; e.rdata = '0;
        if (req_we[p]) ref_mem[a] = req_wdata[p*DW +: DW];
        else e.rdata = ref_mem[a];
        sbq.push_back(e);
      end
      if ((rsp_valid | wr_done) != '0) begin
        chk("done_onehot", $countones({rsp_valid, wr_done}), 1);
        done_cnt++;
        if (sbq.size() == 0) chk("unexpected_completion", {rsp_valid, wr_done}, 0);
        else begin
          e = sbq.pop_front();
          chk("done_port", idx_of(rsp_valid | wr_done), e.port);
          chk("done_kind", (wr_done != '0), e.we);
          if (!e.we) chk("rsp_rdata", rsp_rdata, e.rdata);
        end
      end
    end
  end

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 200) begin @(negedge clk); n++; end
    chk("done_count", done_cnt, target);
  endtask

  task automatic push(input int p, input bit we, input logic [HW-1:0] a, input logic [DW-1:0] d);
    req_t r;
    r.we = we; r.addr = a; r.wd = d;
    if (p == 0) q0.push_back(r); else q1.push_back(r);
  endtask

  typedef struct { int port; bit we; logic [HW-1:0] addr; logic [DW-1:0] wd; logic [DW-1:0] exp_rdata; } vec_t;
  vec_t tbl[9];

  initial begin
    int nw0, nr0, d0, n;
    tbl[0] = '{0, 1, 24'h00ABC1, 16'h1234, 16'h0000};
    tbl[1] = '{0, 0, 24'h00ABC1, 16'h0000, 16'h1234};
    tbl[2] = '{0, 1, 24'h000010, 16'h0A0A, 16'h1234};
    tbl[3] = '{1, 1, 24'h000020, 16'hBEEF, 16'h1234};
    tbl[4] = '{1, 0, 24'h000020, 16'h0000, 16'hBEEF};
    tbl[5] = '{0, 0, 24'h000010, 16'h0000, 16'h0A0A};
    tbl[6] = '{1, 1, 24'hFFFFFF, 16'hFFFF, 16'h0A0A};
    tbl[7] = '{0, 0, 24'hFFFFFF, 16'h0000, 16'hFFFF};
    tbl[8] = '{1, 0, 24'h000000, 16'h0000, 16'h0000};

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {req_ready, rsp_valid, wr_done, ctl_wr_enable, ctl_rd_enable, rsp_rdata}, 0);
    chk("reset_addr", ctl_wr_addr, 0);
    #1 rst_n = 1'b1;

    // single transactions; rsp_rdata must hold across writes
    nw0 = n_wr; nr0 = n_rd;
    for (int i = 0; i < 9; i++) begin
      push(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wd);
      wait_done(done_cnt + 1);
      @(negedge clk);
      chk($sformatf("vec%0d_rdata", i), rsp_rdata, tbl[i].exp_rdata);
      if (i == 0) chk("first_write_one_pulse", n_wr - nw0, 1);
    end
    chk("wr_pulses", n_wr - nw0, 4);
    chk("rd_pulses", n_rd - nr0, 5);

    // both ports continuously requesting
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    gq = '{0, 0, 0, 1, 1, 1};
`else
    gq = '{0, 1, 0, 1, 0, 1};
`endif
    for (int k = 0; k < 3; k++) begin
      push(0, 0, 24'h000010, '0);
      push(1, 0, 24'h000020, '0);
    end
    wait_done(done_cnt + 6);
    chk("grants_consumed", gq.size(), 0);

    // read dropped by refresh: reissued to the same address, answered once
    drop_arm = 1; nr0 = n_rd; rd_addrs.delete();
    push(0, 0, 24'h000010, '0);
    wait_done(done_cnt + 1);
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    chk("drop_no_dup", done_cnt, d0);
    chk("drop_rd_pulses", n_rd - nr0, 2);
    for (int i = 0; i < rd_addrs.size(); i++) chk("retry_addr", rd_addrs[i], 24'h000010);

    // issue ignored: reissue ACCEPT_WAIT cycles after entering S_ACCEPT
    ign_arm = 1; wr_cyc.delete();
    push(1, 1, 24'h000030, 16'h5555);
    wait_done(done_cnt + 1);
    chk("ignore_wr_pulses", wr_cyc.size(), 2);
    if (wr_cyc.size() >= 2) chk("reissue_gap", wr_cyc[1] - wr_cyc[0], AWAIT + 1);
    push(0, 0, 24'h000030, '0);
    wait_done(done_cnt + 1);
    @(negedge clk);
    chk("readback_after_retry", rsp_rdata, 16'h5555);

    // reset while a write is in S_RUN
    push(0, 1, 24'h000040, 16'h7777);
    n = 0;
    while (!ctl_busy && n < 50) begin @(negedge clk); n++; end
    chk("busy_seen", ctl_busy, 1);
    @(negedge clk);
    d0 = done_cnt;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrun_reset_outputs", {req_ready, rsp_valid, wr_done, ctl_wr_enable, ctl_rd_enable, rsp_rdata}, 0);
    chk("midrun_reset_addr", ctl_rd_addr, 0);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_abandoned_done", done_cnt, d0);

    // last_grant restarts at NPORTS-1, so port 0 wins first
    gq = '{0, 1};
    push(0, 0, 24'h000030, '0);
    push(1, 0, 24'h000020, '0);
    wait_done(done_cnt + 2);
    @(negedge clk);
    chk("post_reset_rdata", rsp_rdata, 16'hBEEF);
    chk("post_reset_grants", gq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
Shares one single-beat SDRAM controller between NPORTS host requesters such as the CPU bus bridge and the video fetch engine.
- Requesters are granted round-robin.
- The arbiter issues one read or write at a time to the controller's wr_/rd_ enable interface.
- It confirms acceptance through the controller's busy signal and retries commands the controller dropped because of a refresh.
- Read data is routed back to the requester that issued the read.

Parameters:
NPORTS, 2, number of requesters (2..4)
HADDR_WIDTH, 24, host address width {bank,row,col}
DATA_WIDTH, 16, data width
ACCEPT_WAIT, 3, cycles to wait for ctl_busy to rise after an issue pulse before reissuing (1..7)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
req_valid  in  NPORTS  per-port request pending
req_we  in  NPORTS  1=write, 0=read
req_addr  in  NPORTS*HADDR_WIDTH  per-port address, port p in slice p
req_wdata  in  NPORTS*DATA_WIDTH  per-port write data
req_ready  out  NPORTS  one-hot, 1-cycle; request of port p is consumed this cycle
rsp_valid  out  NPORTS  one-hot, 1-cycle; read data valid for port p
wr_done  out  NPORTS  one-hot, 1-cycle; write of port p completed
rsp_rdata  out  DATA_WIDTH  read data, shared by all ports
ctl_wr_addr  out  HADDR_WIDTH  to controller
ctl_wr_data  out  DATA_WIDTH  to controller
ctl_wr_enable  out  1  to controller
ctl_rd_addr  out  HADDR_WIDTH  to controller
ctl_rd_enable  out  1  to controller
ctl_rd_data  in  DATA_WIDTH  from controller
ctl_rd_ready  in  1  from controller, 1-cycle pulse
ctl_busy  in  1  from controller; registered, so it lags the controller state by 1 cycle

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all outputs 0, state S_IDLE, last_grant=NPORTS-1;
  - any in-flight transaction is abandoned and no completion pulse is produced.
- Latched transaction registers: g (grant index), we_r, addr_r, wdata_r.
- ctl_wr_addr = ctl_rd_addr = addr_r at all times; ctl_wr_data = wdata_r.
- States:
  - S_IDLE: if ctl_busy=0 and |req_valid:
    - g = first set req_valid bit searching from last_grant+1 upward, wrapping modulo NPORTS;
    - latch req_we[g], req_addr slice g, req_wdata slice g;
    - req_ready[g]=1 this cycle (combinational from state, ctl_busy and req_valid);
    - last_grant<=g; go to S_ISSUE.
    - If ctl_busy=1 or no request, stay in S_IDLE.
  - S_ISSUE: ctl_wr_enable=we_r and ctl_rd_enable=~we_r, asserted for exactly this cycle; wcnt<=0; go to S_ACCEPT.
  - S_ACCEPT:
    - if ctl_busy=1, go to S_RUN;
    - else if wcnt==ACCEPT_WAIT-1, go to S_ISSUE (reissue the same transaction);
    - else wcnt++.
  - S_RUN, read (we_r=0):
    - on ctl_rd_ready=1: rsp_rdata<=ctl_rd_data; rsp_valid[g]=1 in the following cycle; go to S_GAP.
    - else if ctl_busy=0: the command was dropped because the controller serviced a refresh; go to S_ISSUE to retry.
  - S_RUN, write (we_r=1): on ctl_busy=0, pulse wr_done[g] for 1 cycle and go to S_GAP.
  - S_GAP: one dead cycle that absorbs the 1-cycle staleness of ctl_busy; go to S_IDLE.
- rsp_rdata holds its value until the next read completes.
- Latency: an unloaded read runs from req_ready to rsp_valid in ≈ controller read latency + 4 cycles.
- Only one transaction is in flight. req_ready is never asserted outside S_IDLE.
- Requesters must hold req_valid/addr/data stable until req_ready. Dropping req_valid before grant is legal; the request is simply not served.
- Simultaneous requests on all ports are served strictly rotating, so each port waits at most NPORTS-1 transactions.

Optional Feature:
- SDRAM_ARB_FIXED_PRIO_EN defined: grant is the lowest-indexed set req_valid bit (port 0 highest priority); last_grant is unused.
- Not defined: round-robin as specified above.

Decomposition:
- Package sdram_arb_pkg holds:
  - state enum (S_IDLE, S_ISSUE, S_ACCEPT, S_RUN, S_GAP);
  - localparam for max NPORTS;
  - function rr_pick(req, last) returning the index.
- Sub-module sdram_rr_picker: combinational round-robin/fixed-priority selector. Inputs: req vector, last_grant. Outputs: grant index and valid.

Test Plan:
1. Port0 write 0x00ABC1/0x1234, then port0 read 0x00ABC1 -> exactly one ctl_wr_enable pulse, wr_done[0] once, then rsp_valid[0] with rsp_rdata=0x1234.
2. Ports 0 and 1 hold req_valid with reads to 0x000010/0x000020, six transactions -> grant order 0,1,0,1,0,1; no rsp_valid on the wrong port.
3. Model drops the read, busy high for 6 cycles with no rd_ready, then low (refresh) -> arbiter reissues the same address; one rsp_valid only.
4. Model ignores the issue pulse (busy stays 0) -> reissue exactly ACCEPT_WAIT=3 cycles after S_ACCEPT entry.
5. rst_n low for 1 cycle during S_RUN -> all outputs 0 next cycle; no rsp_valid/wr_done for the abandoned op.
6. With SDRAM_ARB_FIXED_PRIO_EN, ports 0 and 1 continuously requesting -> port 1 never granted while port 0 is valid.
